// File: rtl/adc_mon_pkg.sv
// adc_mon_pkg: shared constants for the ADC level monitor.
//   CFG_* : configuration write addresses (cfg_addr)
//   RD_*  : read-back select addresses (rd_addr)
//   state_t : monitor run state (IDLE / RUN / HOLD)
package adc_mon_pkg;

  localparam logic [3:0] CFG_CTRL     = 4'd0;
  localparam logic [3:0] CFG_WIN_LEN  = 4'd1;
  localparam logic [3:0] CFG_OVFL_THR = 4'd2;
  localparam logic [3:0] CFG_CLR      = 4'd3;
  localparam logic [3:0] CFG_THR0     = 4'd8;

  localparam logic [3:0] RD_CTRL      = 4'd0;
  localparam logic [3:0] RD_WIN_LEN   = 4'd1;
  localparam logic [3:0] RD_OVFL_THR  = 4'd2;
  localparam logic [3:0] RD_PEAK      = 4'd4;
  localparam logic [3:0] RD_OVFL_CNT  = 4'd5;
  localparam logic [3:0] RD_LCNT0     = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/adc_mag_sat.sv
// adc_mag_sat: registered saturating absolute value of a signed ADC sample.
//   adc_clk  : clock
//   reset    : synchronous active-high reset
//   adc_data : signed sample
//   mag      : |adc_data| on ADC_BITS-1 bits, most-negative code saturates
//              to the largest positive magnitude
module adc_mag_sat
  import adc_mon_pkg::*;
#(
  parameter int ADC_BITS = 14
) (
  input  logic                       adc_clk,
  input  logic                       reset,
  input  logic signed [ADC_BITS-1:0] adc_data,
  output logic        [ADC_BITS-2:0] mag
);

  localparam logic [ADC_BITS-1:0] MOST_NEG = {1'b1, {(ADC_BITS-1){1'b0}}};

  logic [ADC_BITS-1:0] neg_s;
  logic [ADC_BITS-2:0] mag_s;
  logic [ADC_BITS-2:0] mag_r;

  // Absolute value; two's complement negation of the most-negative code would wrap.
  always_comb begin
    neg_s = ~adc_data + {{(ADC_BITS-1){1'b0}}, 1'b1};
    if (adc_data == MOST_NEG) begin
      mag_s = {(ADC_BITS-1){1'b1}};
    end else if (adc_data[ADC_BITS-1]) begin
      mag_s = neg_s[ADC_BITS-2:0];
    end else begin
      mag_s = adc_data[ADC_BITS-2:0];
    end
  end

  // Pipeline stage 1 register.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      mag_r <= '0;
    end else begin
      mag_r <= mag_s;
    end
  end

  assign mag = mag_r;

endmodule

// File: rtl/adc_level_mon_n.sv
// adc_level_mon_n: ADC health monitor in the adc_clk domain.
//   Counts samples at/above NLEV magnitude thresholds (saturating counters,
//   optional per-level overflow-pin mode), measures per-window overflow count
//   and peak magnitude, and runs continuously or as a one-shot capture.
// Ports:
//   adc_clk, reset        : clock, synchronous active-high reset
//   adc_data, adc_ovfl    : sample and overflow pin, valid every cycle
//   cfg_wr/addr/data      : configuration write port
//   rd_addr / rd_data     : read select / registered read data
//   ovfl_A                : pulse when a window's overflow count met OVFL_THR
//   win_done              : pulse at every window end
//   peak_mag              : peak magnitude of the last completed window
//   busy                  : monitor is in RUN
module adc_level_mon_n
  import adc_mon_pkg::*;
#(
  parameter int ADC_BITS = 14,
  parameter int NLEV     = 2,
  parameter int WIN_BITS = 16,
  parameter int CNT_W    = 32
) (
  input  logic                       adc_clk,
  input  logic                       reset,
  input  logic signed [ADC_BITS-1:0] adc_data,
  input  logic                       adc_ovfl,
  input  logic                       cfg_wr,
  input  logic        [3:0]          cfg_addr,
  input  logic        [31:0]         cfg_data,
  input  logic        [3:0]          rd_addr,
  output logic        [31:0]         rd_data,
  output logic                       ovfl_A,
  output logic                       win_done,
  output logic        [ADC_BITS-2:0] peak_mag,
  output logic                       busy
);

  localparam int MW = ADC_BITS - 1;

  state_t                          state_r;
  logic                            busy_r;
  logic [2:0]                      ctrl_r;
  logic [WIN_BITS-1:0]             win_len_r, ovfl_thr_r;
  logic [WIN_BITS-1:0]             wcnt_r, ocnt_r, last_ocnt_r, ocnt_nx_s;
  logic [MW-1:0]                   mag_r, peak_acc_r, peak_mag_r, peak_nx_s;
  logic                            ovfl_r, win_done_r, ovfl_a_r;
  logic [NLEV-1:0][ADC_BITS-1:0]   thr_r;
  logic [NLEV-1:0][CNT_W-1:0]      lcnt_s;
  logic [NLEV-1:0]                 wr_thr_s;
  logic [31:0]                     rd_s, rd_data_r;
  logic wr_ctrl_s, wr_win_s, wr_othr_s, wr_clr_s;
  logic en_nx_s, os_nx_s, start_s, restart_s, run_s, win_end_s;
  logic unused_cfg_s;

  adc_mag_sat #(.ADC_BITS(ADC_BITS)) u_mag (
    .adc_clk  (adc_clk),
    .reset    (reset),
    .adc_data (adc_data),
    .mag      (mag_r)
  );

  assign wr_ctrl_s = cfg_wr && (cfg_addr == CFG_CTRL);
  assign wr_win_s  = cfg_wr && (cfg_addr == CFG_WIN_LEN);
  assign wr_othr_s = cfg_wr && (cfg_addr == CFG_OVFL_THR);
  assign wr_clr_s  = cfg_wr && (cfg_addr == CFG_CLR);
  assign unused_cfg_s = ^cfg_data;

  // Per-level threshold write decode.
  always_comb begin
    for (int i = 0; i < NLEV; i++) begin
      wr_thr_s[i] = cfg_wr && (cfg_addr == (CFG_THR0 + 4'(i)));
    end
  end

  // Control bits as they will be after this cycle, so a CTRL write acts at once.
  always_comb begin
    if (wr_ctrl_s) begin
      en_nx_s = cfg_data[0];
      os_nx_s = cfg_data[1];
      start_s = cfg_data[2];
    end else begin
      en_nx_s = ctrl_r[0];
      os_nx_s = ctrl_r[1];
      start_s = 1'b0;
    end
  end

  // Window bookkeeping; a restart pre-empts a window end in the same cycle.
  always_comb begin
    restart_s = start_s | wr_win_s | wr_othr_s;
    run_s     = (state_r == RUN);
    win_end_s = run_s && en_nx_s && !restart_s && (wcnt_r == win_len_r);
    if (ovfl_r && (ocnt_r != {WIN_BITS{1'b1}})) begin
      ocnt_nx_s = ocnt_r + WIN_BITS'(1);
    end else begin
      ocnt_nx_s = ocnt_r;
    end
    if (mag_r > peak_acc_r) begin
      peak_nx_s = mag_r;
    end else begin
      peak_nx_s = peak_acc_r;
    end
  end

  // Stage-1 copy of the overflow pin, aligned with the registered magnitude.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      ovfl_r <= 1'b0;
    end else begin
      ovfl_r <= adc_ovfl;
    end
  end

  // Configuration registers; the start bit self-clears after one cycle.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      ctrl_r     <= 3'd0;
      win_len_r  <= {WIN_BITS{1'b1}};
      ovfl_thr_r <= '0;
      for (int i = 0; i < NLEV; i++) begin
        thr_r[i] <= {1'b0, {(ADC_BITS-1){1'b1}}};
      end
    end else begin
      ctrl_r <= {start_s, os_nx_s, en_nx_s};
      if (wr_win_s) win_len_r <= cfg_data[WIN_BITS-1:0];
      else          win_len_r <= win_len_r;
      if (wr_othr_s) ovfl_thr_r <= cfg_data[WIN_BITS-1:0];
      else           ovfl_thr_r <= ovfl_thr_r;
      for (int i = 0; i < NLEV; i++) begin
        if (wr_thr_s[i]) thr_r[i] <= cfg_data[ADC_BITS-1:0];
        else             thr_r[i] <= thr_r[i];
      end
    end
  end

  // Run-state FSM; busy is registered alongside the state.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else if (!en_nx_s) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else if (start_s) begin
      state_r <= RUN;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (!os_nx_s) begin state_r <= RUN;  busy_r <= 1'b1; end
          else          begin state_r <= IDLE; busy_r <= 1'b0; end
        end
        RUN: begin
          if (win_end_s && os_nx_s) begin state_r <= HOLD; busy_r <= 1'b0; end
          else                      begin state_r <= RUN;  busy_r <= 1'b1; end
        end
        HOLD:    begin state_r <= HOLD; busy_r <= 1'b0; end
        default: begin state_r <= IDLE; busy_r <= 1'b0; end
      endcase
    end
  end

  // Window counter, overflow/peak accumulators and window-end results.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      wcnt_r      <= '0;
      ocnt_r      <= '0;
      peak_acc_r  <= '0;
      win_done_r  <= 1'b0;
      ovfl_a_r    <= 1'b0;
      peak_mag_r  <= '0;
      last_ocnt_r <= '0;
    end else begin
      win_done_r <= 1'b0;
      ovfl_a_r   <= 1'b0;
      if (win_end_s) begin
        win_done_r  <= 1'b1;
        ovfl_a_r    <= (ovfl_thr_r != '0) && (ocnt_nx_s >= ovfl_thr_r);
        peak_mag_r  <= peak_nx_s;
        last_ocnt_r <= ocnt_nx_s;
        wcnt_r      <= '0;
        ocnt_r      <= '0;
        peak_acc_r  <= '0;
      end else if (run_s && en_nx_s && !restart_s) begin
        wcnt_r     <= wcnt_r + WIN_BITS'(1);
        ocnt_r     <= ocnt_nx_s;
        peak_acc_r <= peak_nx_s;
      end else begin
        wcnt_r     <= '0;
        ocnt_r     <= '0;
        peak_acc_r <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < NLEV; gi++) begin : g_lvl
    logic [CNT_W-1:0] cnt_r;
    logic             hit_s, clr_s;

    assign clr_s = wr_clr_s | start_s | wr_thr_s[gi];
    // In overflow mode the level counts overflow-pin cycles instead of magnitude hits.
    assign hit_s = thr_r[gi][ADC_BITS-1] ? ovfl_r : (mag_r >= thr_r[gi][ADC_BITS-2:0]);

    // Saturating level counter; a clear beats a coincident hit.
    always_ff @(posedge adc_clk) begin
      if (reset) begin
        cnt_r <= '0;
      end else if (clr_s) begin
        cnt_r <= '0;
      end else if (run_s && hit_s && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign lcnt_s[gi] = cnt_r;
  end

  // Read-back multiplexer.
  always_comb begin
    case (rd_addr)
      RD_CTRL:     rd_s = {27'd0, state_r, ctrl_r};
      RD_WIN_LEN:  rd_s = 32'(win_len_r);
      RD_OVFL_THR: rd_s = 32'(ovfl_thr_r);
      RD_PEAK:     rd_s = 32'(peak_mag_r);
      RD_OVFL_CNT: rd_s = 32'(last_ocnt_r);
      default:     rd_s = 32'd0;
    endcase
    for (int i = 0; i < NLEV; i++) begin
      rd_s = (rd_addr == (RD_LCNT0 + 4'(i))) ? 32'(lcnt_s[i]) : rd_s;
    end
  end

  // Registered read data.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      rd_data_r <= 32'd0;
    end else begin
      rd_data_r <= rd_s;
    end
  end

  assign rd_data  = rd_data_r;
  assign ovfl_A   = ovfl_a_r;
  assign win_done = win_done_r;
  assign peak_mag = peak_mag_r;
  assign busy     = busy_r;

endmodule

// File: doc/adc_level_mon_n.md
# adc_level_mon_n

Parametrised ADC health monitor in the `adc_clk` domain, the successor to the single-threshold overflow and level logic inside the wideband receiver. It counts samples at or above NLEV programmable magnitude thresholds, with saturating counters and a per-level overflow-count mode. It also produces windowed overflow detection and windowed peak magnitude, and runs either continuously or as a one-shot gated capture. The CPU-side sync into this domain (freeze/SYNC_PULSE) is upstream and outside this block.

## Interface
Parameters:
- `ADC_BITS`, 14, ADC sample width (signed).
- `NLEV`, 2, number of level thresholds/counters (1..8).
- `WIN_BITS`, 16, window-length register width.
- `CNT_W`, 32, level counter width.

Ports:
- `adc_clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `adc_data`  in  ADC_BITS  signed sample, valid every cycle.
- `adc_ovfl`  in  1  ADC overflow pin, sampled every cycle.
- `cfg_wr`  in  1  config write strobe.
- `cfg_addr`  in  4  config register address.
- `cfg_data`  in  32  config write data.
- `rd_addr`  in  4  read select.
- `rd_data`  out  32  registered read data.
- `ovfl_A`  out  1  one-cycle pulse: window overflow count met threshold.
- `win_done`  out  1  one-cycle pulse at each window end.
- `peak_mag`  out  ADC_BITS-1  peak magnitude of last completed window.
- `busy`  out  1  state == RUN.

## Operation
- Magnitude: `mag = |adc_data|`, saturating; -2^(ADC_BITS-1) maps to 2^(ADC_BITS-1)-1. Width ADC_BITS-1. Registered (pipeline stage 1).
- Config map:
  - 0 CTRL: bit0 enable, bit1 oneshot, bit2 start (self-clearing).
  - 1 WIN_LEN: window = WIN_LEN+1 samples.
  - 2 OVFL_THR: WIN_BITS wide.
  - 3 CLR: any write clears all level counters.
  - 8+i THR[i]: bits [ADC_BITS-2:0] threshold, bit ADC_BITS-1 ovfl-mode.
- Read map: 0 {state, CTRL}, 1 WIN_LEN, 2 OVFL_THR, 4 peak_mag, 5 last window overflow count, 8+i LCNT[i]. Unmapped addresses read 0.
- States:
  - IDLE: no accumulation; counters hold.
  - RUN: accumulate.
  - HOLD: one-shot results frozen.
- Transitions:
  - IDLE→RUN when enable=1 and oneshot=0, or on start.
  - RUN→HOLD at window end when oneshot=1.
  - HOLD→RUN on start.
  - Any state→IDLE when enable=0.
- Level counters, RUN only:
  - LCNT[i] increments when `mag >= THR[i]`, or in ovfl-mode when `adc_ovfl`=1.
  - Saturate at all-ones; no wrap.
  - Cleared by CLR, by a write to THR[i], and on every start strobe.
- Window: counter wcnt runs in RUN and counts 0..WIN_LEN. Per window it accumulates the overflow count (WIN_BITS, saturating) and the peak of mag.
- At wcnt==WIN_LEN:
  - Pulse win_done.
  - Pulse ovfl_A if OVFL_THR≠0 and count ≥ OVFL_THR.
  - Latch peak_mag and the count.
  - Restart the accumulators.
- Boundaries:
  - A write to WIN_LEN or OVFL_THR restarts the current window: wcnt=0, accumulators cleared, no win_done.
  - Clear and increment in the same cycle: clear wins.
  - WIN_LEN=0 gives a 1-sample window, with win_done every sample.
  - start while RUN restarts the window and clears counters.
  - reset mid-window discards all partial results.

## Timing
- Reset values: rd_data=0, ovfl_A=0, win_done=0, peak_mag=0, busy=0, state=IDLE, CTRL=0, WIN_LEN=all-ones, OVFL_THR=0, THR[i]=all-ones magnitude (full-scale only), LCNT=0.
- Pipeline: sample at cycle t enters mag at t+1; LCNT/accumulators reflect it at t+2.
- Window end: for the last window sample at t, win_done/ovfl_A/peak_mag are asserted/updated at t+2.
- Config write at cycle c takes effect for the sample registered in stage 1 at c+1.
- rd_data is valid 1 cycle after rd_addr.

## Structure
- Package `adc_mon_pkg`: CFG_*/RD_* address constants and the state enum (IDLE/RUN/HOLD).
- Sub-module `adc_mag_sat`: registered saturating absolute value.
- The top holds the FSM, window logic and a generate loop over NLEV counters.

## Test plan
- ADC_BITS=14, WIN_LEN=15, continuous, constant adc_data=-8192 → mag=8191; peak_mag=8191; win_done every 16 cycles, first 2 cycles after the 16th sample.
- THR[0]=1000, THR[1]=4000, 100 samples alternating ±2000 → LCNT[0]=100, LCNT[1]=0; then write THR[1] → LCNT[1]=0 next cycle.
- OVFL_THR=4, WIN_LEN=15, adc_ovfl high 3 cycles per window → no ovfl_A; high 4 cycles → ovfl_A pulse once per window; OVFL_THR=0 → never.
- CNT_W=4, THR[0]=0, 20 samples → LCNT[0]=15 (saturated); ovfl-mode bit set → counts only adc_ovfl cycles.
- Oneshot, start, WIN_LEN=7 → busy high 8 samples, one win_done, then HOLD with counters frozen under continued input; second start → counters cleared, RUN.
- reset asserted mid-window with CLR and increment collisions → all outputs return to reset values next cycle; CLR coincident with a threshold hit yields LCNT=0.
